// File: rtl/hd44780_seq_pkg.sv
// Shared definitions for the HD44780 script sequencer: opcodes, field positions, FSM states.
package hd44780_seq_pkg;

    typedef enum logic [1:0] {
        OP_SEND  = 2'b00,
        OP_DELAY = 2'b01,
        OP_JUMP  = 2'b10,
        OP_STOP  = 2'b11
    } opcode_e;

    localparam int RS_BIT  = 8;
    localparam int NYB_BIT = 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_SEND   = 3'd3,
        ST_DELAY  = 3'd4
    } state_e;

    function automatic opcode_e word_op(input logic [15:0] word);
        return opcode_e'(word[15:14]);
    endfunction

endpackage

// File: rtl/hd44780_delay_ctr.sv
// Down-counter for script DELAY words; expire flags the tick that takes the count from 1 to 0.
module hd44780_delay_ctr #(
    parameter int DLY_W = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [DLY_W-1:0] load_val,
    input  logic             dec,
    output logic             expire
);

    logic [DLY_W-1:0] cnt_r;

    // Count register: clear beats load beats decrement; never decrements below zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (dec && (cnt_r != '0)) begin
            cnt_r <= cnt_r - DLY_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expire = dec && (cnt_r == DLY_W'(1));

endmodule

// File: rtl/hd44780_seq.sv
// HD44780 script sequencer: fetches 16-bit script words from a synchronous-read RAM and turns
// them into LCD write requests, tick delays, jumps and stop.
module hd44780_seq
    import hd44780_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DLY_W  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              abort,
    input  logic              tick,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_rs,
    output logic              cmd_nyb,
    output logic [7:0]        cmd_data,
    output logic              busy,
    output logic              done
);

    state_e            state_r, state_nxt_s;
    logic [ADDR_W-1:0] raddr_r, raddr_nxt_s;
    logic              valid_r, valid_nxt_s;
    logic              rs_r, rs_nxt_s;
    logic              nyb_r, nyb_nxt_s;
    logic [7:0]        data_r, data_nxt_s;
    logic              busy_r;
    logic              done_r, done_nxt_s;
    logic              cnt_clr_s, cnt_load_s, cnt_dec_s, cnt_expire_s;
    logic [ADDR_W-1:0] raddr_inc_s;

    assign raddr_inc_s = raddr_r + ADDR_W'(1);

    hd44780_delay_ctr #(.DLY_W(DLY_W)) u_delay_ctr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (cnt_clr_s),
        .load     (cnt_load_s),
        .load_val (ram_dout[DLY_W-1:0]),
        .dec      (cnt_dec_s),
        .expire   (cnt_expire_s)
    );

    // Next-state and datapath decode; abort overrides every transition.
    always_comb begin
        state_nxt_s = state_r;
        raddr_nxt_s = raddr_r;
        valid_nxt_s = valid_r;
        rs_nxt_s    = rs_r;
        nyb_nxt_s   = nyb_r;
        data_nxt_s  = data_r;
        done_nxt_s  = 1'b0;
        cnt_clr_s   = 1'b0;
        cnt_load_s  = 1'b0;
        cnt_dec_s   = 1'b0;
        if (abort) begin
            state_nxt_s = ST_IDLE;
            valid_nxt_s = 1'b0;
            cnt_clr_s   = 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        raddr_nxt_s = start_addr;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_nxt_s = ST_DECODE;
                end
                ST_DECODE: begin
                    case (word_op(ram_dout[15:0]))
                        OP_SEND: begin
                            rs_nxt_s    = ram_dout[RS_BIT];
                            nyb_nxt_s   = ram_dout[NYB_BIT];
                            data_nxt_s  = ram_dout[7:0];
                            valid_nxt_s = 1'b1;
                            state_nxt_s = ST_SEND;
                        end
                        OP_DELAY: begin
                            if (ram_dout[DLY_W-1:0] == '0) begin
                                raddr_nxt_s = raddr_inc_s;
                                state_nxt_s = ST_FETCH;
                            end else begin
                                cnt_load_s  = 1'b1;
                                state_nxt_s = ST_DELAY;
                            end
                        end
                        OP_JUMP: begin
                            raddr_nxt_s = ADDR_W'(ram_dout[7:0]);
                            state_nxt_s = ST_FETCH;
                        end
                        OP_STOP: begin
                            done_nxt_s  = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end
                ST_SEND: begin
                    if (cmd_ready) begin
                        valid_nxt_s = 1'b0;
                        raddr_nxt_s = raddr_inc_s;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_SEND;
                    end
                end
                ST_DELAY: begin
                    cnt_dec_s = tick;
                    if (cnt_expire_s) begin
                        raddr_nxt_s = raddr_inc_s;
                        state_nxt_s = ST_FETCH;
                    end else begin
                        state_nxt_s = ST_DELAY;
                    end
                end
                default: begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers; busy is registered from the next state so it falls with done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            raddr_r <= '0;
            valid_r <= 1'b0;
            rs_r    <= 1'b0;
            nyb_r   <= 1'b0;
            data_r  <= 8'h00;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            raddr_r <= raddr_nxt_s;
            valid_r <= valid_nxt_s;
            rs_r    <= rs_nxt_s;
            nyb_r   <= nyb_nxt_s;
            data_r  <= data_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            done_r  <= done_nxt_s;
        end
    end

    assign ram_raddr = raddr_r;
    assign cmd_valid = valid_r;
    assign cmd_rs    = rs_r;
    assign cmd_nyb   = nyb_r;
    assign cmd_data  = data_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule
